// File: rtl/dt_estimator_mc_if.sv
// Sample/result stream bundle for dt_estimator_mc: upstream samples in, smoothed dT results out.
// The master side sources samples and sinks results; the estimator uses the slave side.
interface dt_estimator_mc_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  s_valid;
  logic                  s_ready;
  logic [CHW-1:0]        s_ch;
  logic signed [W-1:0]   s_T;
  logic                  s_init;
  logic                  m_valid;
  logic                  m_ready;
  logic [CHW-1:0]        m_ch;
  logic signed [W-1:0]   m_dT;
  logic                  m_dt_valid;

  modport master (
    output s_valid, s_ch, s_T, s_init, m_ready,
    input  s_ready, m_valid, m_ch, m_dT, m_dt_valid
  );

  modport slave (
    input  s_valid, s_ch, s_T, s_init, m_ready,
    output s_ready, m_valid, m_ch, m_dT, m_dt_valid
  );
endinterface

// File: rtl/dt_estimator_mc.sv
// Multi-channel dT estimator: per-channel EMA of scaled temperature delta, clamped, with warm-up flag.
// Optional sticky clamp-hit flags are built only when DT_EST_STATS_EN is defined.
module dt_estimator_mc #(
  parameter int NCH    = 4,
  parameter int W      = 8,
  parameter int FRAC   = 7,
  parameter int WARMUP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dt_estimator_mc_if.slave bus,
  input  logic [7:0]      alpha,
  input  logic [3:0]      k_dt,
  input  logic [W-1:0]    d_max,
  output logic [NCH-1:0]  sat_flags,
  input  logic            sat_clr
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW  = W + FRAC;
  localparam int PW  = W + FRAC + 12;
  localparam logic [W-1:0]         DMAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [3:0]           FRAC4   = 4'(FRAC);
  localparam logic [3:0]           WARM4   = 4'(WARMUP);
  localparam logic signed [PW-1:0] RND_ADD = PW'((1 << FRAC) - 1);

  logic signed [W-1:0]  t_prev_q [NCH];
  logic signed [W-1:0]  t_prev_d [NCH];
  logic signed [EW-1:0] ema_q    [NCH];
  logic signed [EW-1:0] ema_d    [NCH];
  logic [3:0]           warm_q   [NCH];
  logic [3:0]           warm_d   [NCH];

  logic                 m_valid_q, m_valid_d;
  logic [CHW-1:0]       m_ch_q, m_ch_d;
  logic signed [W-1:0]  m_dt_q, m_dt_d;
  logic                 m_dt_valid_q, m_dt_valid_d;

  logic                 accept, ch_ok, hit;
  logic [CHW-1:0]       idx;
  logic [3:0]           k_lim, warm_nx;
  logic [W-1:0]         lim;
  logic signed [W:0]    delta;
  logic signed [PW-1:0] ds_x, ema_x, a_x, na_x, e_raw, dm_x, e_clamp, rnd;

  assign bus.s_ready    = !m_valid_q || bus.m_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_ch       = m_ch_q;
  assign bus.m_dT       = m_dt_q;
  assign bus.m_dt_valid = m_dt_valid_q;

  always_comb begin
    accept  = bus.s_valid && bus.s_ready;
    ch_ok   = (int'(bus.s_ch) < NCH);
    idx     = ch_ok ? bus.s_ch : '0;
    k_lim   = (k_dt > FRAC4) ? FRAC4 : k_dt;
    lim     = (d_max > DMAX) ? DMAX : d_max;
    delta   = {bus.s_T[W-1], bus.s_T} - {t_prev_q[idx][W-1], t_prev_q[idx]};
    ds_x    = {{(PW-W-1){delta[W]}}, delta};
    ds_x    = (ds_x <<< FRAC) >>> k_lim;
    ema_x   = {{(PW-EW){ema_q[idx][EW-1]}}, ema_q[idx]};
    a_x     = {{(PW-8){1'b0}}, alpha};
    na_x    = {{(PW-9){1'b0}}, 9'd256} - a_x;
    e_raw   = (ema_x * na_x + ds_x * a_x) >>> 8;
    dm_x    = {{(PW-W){1'b0}}, lim} <<< FRAC;
    hit     = 1'b0;
    e_clamp = e_raw;
    if (e_raw > dm_x) begin
      e_clamp = dm_x;
      hit     = 1'b1;
    end else if (e_raw < -dm_x) begin
      e_clamp = -dm_x;
      hit     = 1'b1;
    end
    // Bias negatives up so the arithmetic shift truncates toward zero.
    rnd     = e_clamp[PW-1] ? e_clamp + RND_ADD : e_clamp;
    warm_nx = (warm_q[idx] < WARM4) ? warm_q[idx] + 4'd1 : warm_q[idx];

    t_prev_d     = t_prev_q;
    ema_d        = ema_q;
    warm_d       = warm_q;
    m_valid_d    = m_valid_q && !bus.m_ready;
    m_ch_d       = m_ch_q;
    m_dt_d       = m_dt_q;
    m_dt_valid_d = m_dt_valid_q;
    if (accept && ch_ok) begin
      m_valid_d     = 1'b1;
      m_ch_d        = idx;
      t_prev_d[idx] = bus.s_T;
      if (bus.s_init) begin
        ema_d[idx]   = '0;
        warm_d[idx]  = '0;
        m_dt_d       = '0;
        m_dt_valid_d = 1'b0;
      end else begin
        ema_d[idx]   = e_clamp[EW-1:0];
        warm_d[idx]  = warm_nx;
        m_dt_d       = W'(rnd >>> FRAC);
        m_dt_valid_d = (warm_nx == WARM4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_ch_q       <= '0;
      m_dt_q       <= '0;
      m_dt_valid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        t_prev_q[i] <= '0;
        ema_q[i]    <= '0;
        warm_q[i]   <= '0;
      end
    end else begin
      m_valid_q    <= m_valid_d;
      m_ch_q       <= m_ch_d;
      m_dt_q       <= m_dt_d;
      m_dt_valid_q <= m_dt_valid_d;
      t_prev_q     <= t_prev_d;
      ema_q        <= ema_d;
      warm_q       <= warm_d;
    end
  end

`ifdef DT_EST_STATS_EN
  logic [NCH-1:0] sat_q, sat_d;

  // A clamp on the same cycle as a clear still leaves the flag set.
  always_comb begin
    sat_d = sat_q;
    if (sat_clr) sat_d = '0;
    if (accept && ch_ok && !bus.s_init && hit) sat_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end

  assign sat_flags = sat_q;
`else
  logic unused_stats;
  assign unused_stats = sat_clr ^ hit;
  assign sat_flags    = '0;
`endif

endmodule

// File: tb/tb_dt_estimator_mc.sv
// Scoreboard bench for dt_estimator_mc: driver pushes model results, monitor pops on each handshake.
// Uses NCH=3 so an out-of-range channel id exists; WARMUP=3 to exercise warm-up.
module tb_dt_estimator_mc;
  localparam int NCH    = 3;
  localparam int W      = 8;
  localparam int FRAC   = 7;
  localparam int WARMUP = 3;

  typedef struct {int ch; int dt; int dv; int dm;} exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     alpha = '0;
  logic [3:0]     k_dt = '0;
  logic [7:0]     d_max = '0;
  logic [NCH-1:0] sat_flags;
  logic           sat_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  exp_t expq[$];
  int   tp[NCH];
  int   em[NCH];
  int   wm[NCH];
  logic [NCH-1:0] sat_m = '0;

  dt_estimator_mc_if #(.NCH(NCH), .W(W)) bus ();

  dt_estimator_mc #(.NCH(NCH), .W(W), .FRAC(FRAC), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .alpha(alpha), .k_dt(k_dt),
    .d_max(d_max), .sat_flags(sat_flags), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      tp[i] = 0; em[i] = 0; wm[i] = 0;
    end
    sat_m = '0;
    expq.delete();
  endfunction

  // Reference: plain integer arithmetic in Q.FRAC units.
  function automatic void model_accept(int ch, int t, bit init, int a, int k, int dm);
    int kk, ds, e, lim, dq, out;
    if (ch >= NCH) return;
    if (init) begin
      tp[ch] = t; em[ch] = 0; wm[ch] = 0;
      expq.push_back('{ch, 0, 0, dm});
      return;
    end
    kk  = (k > FRAC) ? FRAC : k;
    ds  = ((t - tp[ch]) * (1 << FRAC)) >>> kk;
    e   = (em[ch] * (256 - a) + ds * a) >>> 8;
    lim = (dm > 127) ? 127 : dm;
    dq  = lim * (1 << FRAC);
    if (e > dq || e < -dq) begin
`ifdef DT_EST_STATS_EN
      sat_m[ch] = 1'b1;
`endif
      e = (e > dq) ? dq : -dq;
    end
    em[ch] = e;
    out    = e / (1 << FRAC);
    tp[ch] = t;
    if (wm[ch] < WARMUP) wm[ch]++;
    expq.push_back('{ch, out, (wm[ch] == WARMUP) ? 1 : 0, dm});
  endfunction

  task automatic send(int ch, int t, bit init, int a, int k, int dm, bit clr);
    bit acc = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_ch    = 2'(ch);
    bus.s_T     = 8'(t);
    bus.s_init  = init;
    alpha       = 8'(a);
    k_dt        = 4'(k);
    d_max       = 8'(dm);
    sat_clr     = clr;
    for (int n = 0; n < 200 && !acc; n++) begin
      #1;
      acc = bus.s_ready;
      @(posedge clk);
`ifdef DT_EST_STATS_EN
      if (clr) sat_m = '0;
`endif
      if (acc) model_accept(ch, t, init, a, k, dm);
      else @(negedge clk);
    end
    #1;
    bus.s_valid = 1'b0;
    sat_clr     = 1'b0;
    chk("send_accept", int'(acc), 1);
    chk("sat_flags", int'(sat_flags), int'(sat_m));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    sat_clr = 1'b1;
    @(posedge clk);
    sat_m = '0;
    #1;
    sat_clr = 1'b0;
    chk("sat_clr", int'(sat_flags), 0);
  endtask

  always @(negedge clk) begin
    case (mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ($urandom_range(0, 3) != 0);
      default: bus.m_ready = 1'b0;
    endcase
  end

  initial begin : monitor
    logic       pv, pr, pdv;
    logic [1:0] pch;
    logic [7:0] pdt;
    exp_t       e;
    int         got_dt, lim;
    pv = 1'b0; pr = 1'b1; pdv = 1'b0; pch = '0; pdt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_valid", int'(bus.m_valid), 1);
        chk("hold_fields", int'({bus.m_ch, bus.m_dT, bus.m_dt_valid}), int'({pch, pdt, pdv}));
      end
      if (bus.m_valid && bus.m_ready) begin
        got_dt = $signed(bus.m_dT);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result ch %0d dT %0d with no pending sample", bus.m_ch, got_dt);
        end else begin
          e   = expq.pop_front();
          lim = (e.dm > 127) ? 127 : e.dm;
          chk("result_ch", int'(bus.m_ch), e.ch);
          chk("result_dT", got_dt, e.dt);
          chk("result_dt_valid", int'(bus.m_dt_valid), e.dv);
          chk("result_within_dmax", int'((got_dt <= lim) && (got_dt >= -lim)), 1);
        end
      end
      pv = bus.m_valid; pr = bus.m_ready; pch = bus.m_ch; pdt = bus.m_dT; pdv = bus.m_dt_valid;
    end
  end

  initial begin : driver
    bus.s_valid = 1'b0; bus.s_ch = '0; bus.s_T = '0; bus.s_init = 1'b0; bus.m_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_ch", int'(bus.m_ch), 0);
    chk("rst_m_dT", int'(bus.m_dT), 0);
    chk("rst_m_dt_valid", int'(bus.m_dt_valid), 0);
    chk("rst_sat_flags", int'(sat_flags), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_ready", int'(bus.s_ready), 1);

    // Basic EMA on ch0, alpha=1/2
    send(0, 0, 1, 128, 0, 64, 0);
    send(0, 40, 0, 128, 0, 64, 0);
    send(0, 40, 0, 128, 0, 64, 0);
    // Clamp on ch1, then clear flags
    send(1, 0, 1, 255, 0, 10, 0);
    send(1, 127, 0, 255, 0, 10, 0);
    send(1, -128, 0, 255, 0, 10, 0);
    pulse_clr();
    // Interleaved channels
    send(0, 0, 1, 128, 0, 64, 0);
    send(2, 0, 1, 128, 0, 64, 0);
    send(0, 40, 0, 128, 0, 64, 0);
    send(2, 0, 0, 128, 0, 64, 0);
    send(0, 40, 0, 128, 0, 64, 0);
    // Warm-up, k_dt limit, out-of-range channel
    send(2, 10, 1, 32, 3, 100, 0);
    send(2, 50, 0, 32, 3, 100, 0);
    send(2, 90, 0, 32, 3, 100, 0);
    send(2, 120, 0, 32, 3, 100, 0);
    send(2, -60, 0, 32, 12, 100, 0);
    send(3, 77, 0, 32, 3, 100, 0);
    send(2, -60, 0, 32, 7, 100, 0);

    // Backpressure: one result parked, next sample must wait
    repeat (3) @(negedge clk);
    mode = 2;
    send(0, 20, 0, 200, 1, 90, 0);
    fork
      send(1, 5, 0, 200, 1, 90, 0);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_s_ready", int'(bus.s_ready), 0);
    end
    mode = 0;
    wait fork;

    // Random walk under random backpressure
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 7) == 0),
           $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 255),
           ($urandom_range(0, 15) == 0));
    end

    // Async reset with a result parked on the output
    mode = 0;
    repeat (3) @(negedge clk);
    mode = 2;
    send(1, 33, 0, 100, 0, 50, 0);
    @(negedge clk);
    #3;
    chk("pre_rst_m_valid", int'(bus.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", int'(bus.m_valid), 0);
    chk("async_rst_m_dT", int'(bus.m_dT), 0);
    chk("async_rst_sat", int'(sat_flags), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    mode  = 0;
    send(1, 0, 0, 128, 0, 64, 0);
    send(1, 0, 0, 128, 0, 64, 0);
    send(1, 0, 0, 128, 0, 64, 0);
    send(0, 60, 0, 128, 0, 64, 0);

    for (int n = 0; n < 100 && expq.size() > 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dt_estimator_mc.md
Name: dt_estimator_mc

Overview:
Parametrised, multi-channel successor of the single-channel dT estimator. It keeps per-channel state (previous temperature, EMA of scaled delta in fixed point, warm-up counter) for NCH channels. Samples arrive time-multiplexed over a valid/ready stream. For each accepted sample the block emits one smoothed, clamped dT result with channel tag and a validity flag. It sits between the multiplexed sensor front-end and the per-channel control loops.

Parameters:
NCH, 4, number of channels (1..16)
W, 8, signed width of T input and dT output (Q(W-1).0)
FRAC, 7, fraction bits of internal EMA state (Q.FRAC)
WARMUP, 1, non-init samples a channel must accept after init/reset before dt_valid asserts (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept sample
s_ch  in  $clog2(NCH) (min 1)  channel id of sample
s_T  in  W signed  current temperature
s_init  in  1  sample is an INIT sample for s_ch
alpha  in  8  EMA weight, alpha/256
k_dt  in  4  delta divisor exponent, /2^k
d_max  in  W unsigned  |dT| clamp, Q(W-1).0
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_ch  out  $clog2(NCH)  channel of result
m_dT  out  W signed  estimated dT
m_dt_valid  out  1  channel warmed up
sat_flags  out  NCH  sticky clamp-hit flags (see Optional Feature)
sat_clr  in  1  clear sat_flags

Behaviour:
- Reset is asynchronous and active-low. During reset: m_valid=0, m_ch=0, m_dT=0, m_dt_valid=0, sat_flags=0. Every channel has T_prev=0, ema=0, warm=0. s_ready=1 after reset release.
- Handshake: s_ready = !m_valid || m_ready. A sample is accepted on a clk edge with s_valid&&s_ready. Latency is 1 cycle: the result is registered on the accept edge. m_* hold stable while m_valid&&!m_ready. Back-to-back same-channel samples are legal at full rate, because state updates on the accept edge.
- s_ch >= NCH: sample accepted and dropped. No state change, no result.
- alpha, k_dt and d_max are sampled on the accept edge. k_dt is limited to min(k_dt, FRAC).
- INIT sample (s_init=1):
  - T_prev[ch]=s_T, ema[ch]=0, warm[ch]=0.
  - Result: m_dT=0, m_dt_valid=0, sat_flags unchanged.
- Normal sample:
  - delta = s_T - T_prev (W+1 bits).
  - ds = (delta <<< FRAC) >>> k.
  - e = (ema*(256-alpha) + ds*alpha) >>> 8, computed with at least W+FRAC+10 bits and no overflow.
  - dm = min(d_max, 2^(W-1)-1) <<< FRAC.
  - Clamp e to [-dm, +dm]; the clamped value is written back to ema[ch].
  - m_dT = clamped value rounded toward zero: (e<0 ? e+2^FRAC-1 : e) >>> FRAC.
  - T_prev[ch]=s_T.
  - warm[ch] = sat_inc(warm, WARMUP).
  - m_dt_valid = (new warm == WARMUP).
- alpha=0 keeps ema unchanged; alpha=255 is not an exact replace (weight 255/256). Both are legal.
- Channels are fully independent. Traffic on one channel never alters another channel's state.
- Downstream stall does not alter state; samples are simply not accepted.

Optional Feature:
DT_EST_STATS_EN:
- With the macro: sat_flags[ch] is set when a normal sample on ch is clamped, i.e. unclamped e exceeds ±dm.
  - The flag is sticky until a sat_clr cycle.
  - Set and clear in the same cycle: set wins.
- Without the macro: sat_flags is tied to 0, sat_clr is ignored, and no flag registers are synthesised.

Test Plan:
1. W=8, FRAC=7, alpha=128, k=0, d_max=64.
   - ch0: INIT T=0 -> m_dT=0, m_dt_valid=0.
   - Then T=40 -> m_dT=20, valid=1.
   - Then T=40 -> m_dT=10.
2. Clamp: alpha=255, k=0, d_max=10.
   - ch1: INIT T=0, then T=127 -> m_dT=10.
   - Then T=-128 -> m_dT=-10.
   - With DT_EST_STATS_EN: sat_flags[1]=1 after both. sat_clr clears it. Without the macro: sat_flags=0 throughout.
3. Channel isolation, parameters as in case 1.
   - Interleave ch0 INIT 0 / ch2 INIT 0 / ch0 T=40 / ch2 T=0 -> ch0 m_dT=20, ch2 m_dT=0.
   - ch0 state unaffected by ch2.
4. Backpressure.
   - Hold m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0; m_* stable.
   - Release -> exactly one result per accepted sample, in order, none lost or duplicated.
5. Warm-up and k_dt: WARMUP=3, alpha=32, k=3.
   - INIT, then 3 samples -> m_dt_valid = 0,0,1 on samples 1..3.
   - k_dt=12 behaves as k=7.
   - s_ch=NCH produces no result.
6. Async reset.
   - Assert rst_n mid-stream with m_valid=1 -> m_valid=0 immediately.
   - After release, first sample T=0 on any channel -> m_dT=0, m_dt_valid=1 (WARMUP=1).
   - Random walk against a bit-accurate model with |m_dT| <= d_max every result.
